// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the sequencing-bus arbiter and its round-robin picker.
package seq_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} arb_state_t;

  localparam int REL_COUNT_W = 16;
  localparam int MAX_REQ     = 16;

  // Index of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seq_bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_bus_arbiter.sv
// Round-robin owner arbitration for a shared configuration bus with watchdog revocation and dead gap.
module seq_bus_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDLE_GAP       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     rel,
  input  logic [NUM_REQ-1:0]     clr_timeout,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     timeout_flag,
  output logic [REL_COUNT_W-1:0] rel_count
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_next;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [7:0]             gap_q, gap_d;
  logic [NUM_REQ-1:0]     gnt_d, flag_d, flag_set, pick;
  logic [REL_COUNT_W-1:0] cnt_d;
  logic [3:0]             owner_idx;
  logic                   pick_vld, rel_hit, expire, grant_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // rel only counts on the bit that currently owns the bus; it beats a same-cycle expiry.
  assign rel_hit   = |(rel & gnt);
  assign expire    = (timer_q == TMR_W'(1));
  assign grant_end = (state_q == ST_GRANT) && (rel_hit || expire);
  assign owner_idx = onehot_to_idx(MAX_REQ'(gnt));
  assign ptr_next  = PTR_W'((int'(owner_idx) + 1) % NUM_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt          <= '0;
      busy         <= 1'b0;
      timeout_flag <= '0;
      rel_count    <= '0;
      ptr_q        <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt          <= gnt_d;
      busy         <= |gnt_d;
      timeout_flag <= flag_d;
      rel_count    <= cnt_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_GRANT;
      ST_GRANT: if (grant_end) state_d = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q <= 8'd1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt;
    timer_d  = timer_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    cnt_d    = rel_count;
    flag_set = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          timer_d = TMR_W'(TIMEOUT_CYCLES);
        end
      end
      ST_GRANT: begin
        if (grant_end) begin
          gnt_d = '0;
          ptr_d = ptr_next;
          gap_d = 8'(IDLE_GAP);
          if (rel_hit) cnt_d = rel_count + REL_COUNT_W'(1);
          else         flag_set = gnt;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_GAP:  gap_d = gap_q - 8'd1;
      default: ;
    endcase
    // A watchdog set in the same cycle as a clear of that bit must survive.
    flag_d = flag_set | (timeout_flag & ~clr_timeout);
  end

endmodule

// File: tb/tb_seq_bus_arbiter.sv
// Scoreboard bench: two arbiters (gap 1 and gap 0) against an owner/countdown reference model.
module tb_seq_bus_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, rel = '0, clr = '0;
  logic [3:0] gnt_a, flag_a, gnt_b, flag_b;
  logic       busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  seq_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .IDLE_GAP(1)) dut_a (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .clr_timeout(clr),
    .gnt(gnt_a), .busy(busy_a), .timeout_flag(flag_a), .rel_count(cnt_a));

  seq_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .IDLE_GAP(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .clr_timeout(clr),
    .gnt(gnt_b), .busy(busy_b), .timeout_flag(flag_b), .rel_count(cnt_b));

  // Model: who owns the bus, grant cycles left, dead cycles left before arbitration.
  typedef struct {
    int          owner;
    int          left;
    int          gap;
    int          ptr;
    logic [3:0]  flag;
    logic [15:0] cnt;
  } m_t;

  typedef struct {
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  flag;
    logic [15:0] cnt;
  } obs_t;

  m_t   ma, mb;
  obs_t q_a[$], q_b[$];
  int   checks = 0;
  int   errors = 0;

  task automatic mstep(inout m_t m, input logic [3:0] rq, rl, cl, input logic r, input int gapcfg);
    logic [3:0] set;
    int idx;
    bit found;
    set = '0;
    if (r) begin
      m.owner = -1; m.left = 0; m.gap = 0; m.ptr = 0; m.flag = '0; m.cnt = '0;
      return;
    end
    if (m.owner >= 0) begin
      if (rl[m.owner] || m.left == 1) begin
        if (rl[m.owner]) m.cnt = m.cnt + 16'd1;
        else             set[m.owner] = 1'b1;
        m.ptr   = (m.owner + 1) % N;
        m.owner = -1;
        m.gap   = gapcfg;
      end else begin
        m.left--;
      end
    end else if (m.gap > 0) begin
      m.gap--;
    end else if (rq != 4'b0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m.ptr + k) % N;
        if (!found && rq[idx]) begin
          found   = 1;
          m.owner = idx;
          m.left  = T;
        end
      end
    end
    m.flag = (m.flag & ~cl) | set;
  endtask

  function automatic obs_t expect_of(input m_t m);
    obs_t o;
    o.gnt  = (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0;
    o.busy = (m.owner >= 0);
    o.flag = m.flag;
    o.cnt  = m.cnt;
    return o;
  endfunction

  task automatic cycle(input logic [3:0] rq, rl, cl, input logic r);
    @(negedge clk);
    req = rq; rel = rl; clr = cl; rst = r;
    @(posedge clk);
    mstep(ma, rq, rl, cl, r, 1);
    mstep(mb, rq, rl, cl, r, 0);
    q_a.push_back(expect_of(ma));
    q_b.push_back(expect_of(mb));
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    obs_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0 && q_b.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp("gnt_a",  16'(gnt_a),  16'(ea.gnt));
        cmp("busy_a", 16'(busy_a), 16'(ea.busy));
        cmp("flag_a", 16'(flag_a), 16'(ea.flag));
        cmp("cnt_a",  cnt_a,       ea.cnt);
        cmp("gnt_b",  16'(gnt_b),  16'(eb.gnt));
        cmp("busy_b", 16'(busy_b), 16'(eb.busy));
        cmp("flag_b", 16'(flag_b), 16'(eb.flag));
        cmp("cnt_b",  cnt_b,       eb.cnt);
      end
    end
  end

  initial begin
    logic [3:0] rl, cl, rq;
    int guard;
    repeat (2) cycle(4'h0, 4'h0, 4'h0, 1'b1);

    // Full request, each owner releases a few cycles into its grant.
    repeat (40) begin
      rl = (ma.owner >= 0 && ma.left == T - 3) ? 4'(1 << ma.owner) : 4'h0;
      cycle(4'hF, rl, 4'h0, 1'b0);
    end

    // Lone requester with no release: watchdog revocation, then flag clear.
    repeat (24) cycle(4'b0100, 4'h0, 4'h0, 1'b0);
    cycle(4'h0, 4'h0, 4'b0100, 1'b0);
    repeat (3) cycle(4'h0, 4'h0, 4'h0, 1'b0);

    // Release lands on the expiry cycle.
    repeat (24) begin
      rl = (ma.owner == 2 && ma.left == 1) ? 4'b0100 : 4'h0;
      cycle(4'b0100, rl, 4'h0, 1'b0);
    end

    // Release on a non-granted bit is ignored.
    repeat (6) cycle(4'b0001, 4'b0010, 4'h0, 1'b0);
    cycle(4'b0001, 4'b0001, 4'h0, 1'b0);
    repeat (2) cycle(4'h0, 4'h0, 4'h0, 1'b0);

    // Single requester released every cycle, then dropping req while granted.
    repeat (10) cycle(4'b1000, 4'b1000, 4'h0, 1'b0);
    cycle(4'b1000, 4'h0, 4'h0, 1'b0);
    repeat (4) cycle(4'h0, 4'h0, 4'h0, 1'b0);
    cycle(4'h0, 4'b1000, 4'h0, 1'b0);
    repeat (3) cycle(4'h0, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of a grant, then a two-bit request.
    guard = 0;
    while ((ma.cnt < 16'd5 || ma.owner < 0) && guard < 200) begin
      rl = (ma.owner >= 0 && ma.left == T - 1) ? 4'(1 << ma.owner) : 4'h0;
      cycle(4'hF, rl, 4'h0, 1'b0);
      guard++;
    end
    cmp("reach_mid_grant", 16'(guard < 200), 16'd1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    repeat (5) cycle(4'b0110, 4'h0, 4'h0, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      rq = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        rl[i] = ($urandom_range(5) == 0);
        cl[i] = ($urandom_range(15) == 0);
      end
      if (ma.owner >= 0 && ma.left == 1 && $urandom_range(3) == 0) rl[ma.owner] = 1'b1;
      cycle(rq, rl, cl, $urandom_range(299) == 0);
    end

    repeat (2) @(posedge clk);
    #2;
    cmp("queue_drained", 16'(q_a.size() + q_b.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
